// File: rtl/tsc_pkg.sv
// Shared encodings and the trigger decision for the transient-snapshot capture engine.
package tsc_pkg;

   typedef enum logic [2:0] {
      ST_READY     = 3'd0,
      ST_ARMED     = 3'd1,
      ST_TRIGGERED = 3'd2,
      ST_HOLD      = 3'd3,
      ST_SEND      = 3'd4
   } state_e;

   localparam logic [1:0] MODE_ABOVE = 2'd0;
   localparam logic [1:0] MODE_BELOW = 2'd1;
   localparam logic [1:0] MODE_RISE  = 2'd2;
   localparam logic [1:0] MODE_FALL  = 2'd3;

   // Samples are zero-extended to this width so one function serves any DW <= 32.
   localparam int CMP_W = 32;

   function automatic logic trig_fire(input logic [1:0]       mode,
                                      input logic [CMP_W-1:0] prev,
                                      input logic [CMP_W-1:0] s,
                                      input logic [CMP_W-1:0] level,
                                      input logic             first);
      logic fire;
      fire = 1'b0;
      case (mode)
         MODE_ABOVE: fire = (s > level);
         MODE_BELOW: fire = (s < level);
         MODE_RISE:  fire = !first && (prev <= level) && (s > level);
         MODE_FALL:  fire = !first && (prev >= level) && (s < level);
         default:    fire = 1'b0;
      endcase
      return fire;
   endfunction

endpackage

// File: rtl/tsc_capture_engine_if.sv
// ADC request/ready sample bus between the capture engine (master) and the ADC (slave).
interface tsc_capture_engine_if #(parameter int DW = 8);
   logic          adc_req;
   logic          adc_rdy;
   logic [DW-1:0] adc_data;

   modport master (output adc_req, input adc_rdy, input adc_data);
   modport slave  (input adc_req, output adc_rdy, output adc_data);
endinterface

// File: rtl/tsc_serial_tx.sv
// UART-style frame transmitter: start bit, DW data bits LSB first, stop bit.
module tsc_serial_tx #(
   parameter int DW         = 8,
   parameter int BIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [DW-1:0] data,
   output logic          busy,
   output logic          sd
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int BW = $clog2(DW + 2);

   logic [CW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DW+1:0] shreg_q, shreg_d;
   logic          active_q, active_d;
   logic          last_div, last_bit;

   assign last_div = (div_q == CW'(BIT_CYCLES - 1));
   assign last_bit = (bit_q == BW'(DW + 1));
   // Free during the final stop-bit cycle so the next frame follows with no idle gap.
   assign busy     = active_q && !(last_div && last_bit);
   assign sd       = active_q ? shreg_q[0] : 1'b1;

   always_comb begin
      div_d    = div_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      active_d = active_q;
      if (load && !busy) begin
         shreg_d  = {1'b1, data, 1'b0};
         bit_d    = '0;
         div_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (last_div) begin
            div_d = '0;
            if (last_bit) begin
               active_d = 1'b0;
            end else begin
               bit_d   = bit_q + BW'(1);
               shreg_d = {1'b1, shreg_q[DW+1:1]};
            end
         end else begin
            div_d = div_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q    <= '0;
         bit_q    <= '0;
         active_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         bit_q    <= bit_d;
         active_q <= active_d;
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

endmodule

// File: rtl/tsc_capture_engine.sv
// Trigger-based snapshot capture into a circular buffer, then serial readout of the frozen window.
module tsc_capture_engine
   import tsc_pkg::*;
#(
   parameter int DW         = 8,
   parameter int DEPTH      = 32,
   parameter int POST       = 16,
   parameter int BIT_CYCLES = 1,
   parameter int TW         = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  sbf,
   input  logic [DW-1:0]         trig_level,
   input  logic [1:0]            trig_mode,
   tsc_capture_engine_if.master  adc,
   output logic                  trd,
   output logic                  sd,
   output logic                  cd,
   output logic [2:0]            state,
   output logic [TW-1:0]         trig_time
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(POST + 1);
   localparam int LW = $clog2(BIT_CYCLES + 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d, trig_time_q, trig_time_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FW-1:0] fill_q, fill_d, send_cnt_q, send_cnt_d;
   logic [PW-1:0] post_cnt_q, post_cnt_d;
   logic [LW-1:0] lead_q, lead_d;
   logic          adc_req_q, adc_req_d, trd_q, trd_d, cd_q, cd_d, first_q, first_d;
   logic          start_prev_q, sbf_prev_q;
   logic [DW-1:0] prev_q, prev_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic start_rise, sbf_rise, accept, wr_en, do_arm, tx_load, tx_busy;

   assign start_rise = start && !start_prev_q;
   assign sbf_rise   = sbf && !sbf_prev_q;
   assign accept     = adc_req_q && adc.adc_rdy;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      trig_time_d = trig_time_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      send_cnt_d  = send_cnt_q;
      post_cnt_d  = post_cnt_q;
      lead_d      = lead_q;
      adc_req_d   = adc_req_q;
      trd_d       = trd_q;
      cd_d        = cd_q;
      first_d     = first_q;
      prev_d      = prev_q;
      wr_en       = 1'b0;
      do_arm      = 1'b0;
      tx_load     = 1'b0;
      case (state_q)
         ST_READY: do_arm = start_rise;
         ST_ARMED, ST_TRIGGERED: begin
            timer_d = timer_q + TW'(1);
            // A new request waits until the ADC has released ready from the previous one.
            if (!adc_req_q && !adc.adc_rdy) adc_req_d = 1'b1;
            if (accept) begin
               adc_req_d = 1'b0;
               wr_en     = 1'b1;
               wr_ptr_d  = wr_ptr_q + AW'(1);
               if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
               prev_d    = adc.adc_data;
               first_d   = 1'b0;
               if (state_q == ST_ARMED) begin
                  if (trig_fire(trig_mode, CMP_W'(prev_q), CMP_W'(adc.adc_data),
                                CMP_W'(trig_level), first_q)) begin
                     state_d     = ST_TRIGGERED;
                     trig_time_d = timer_q;
                     post_cnt_d  = PW'(POST);
                  end
               end else begin
                  post_cnt_d = post_cnt_q - PW'(1);
                  if (post_cnt_q == PW'(1)) begin
                     state_d = ST_HOLD;
                     trd_d   = 1'b1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (sbf_rise) begin
               state_d    = ST_SEND;
               cd_d       = 1'b0;
               lead_d     = LW'(BIT_CYCLES - 1);
               send_cnt_d = fill_q;
               rd_ptr_d   = wr_ptr_q - fill_q[AW-1:0];
            end else begin
               do_arm = start_rise;
            end
         end
         ST_SEND: begin
            if (lead_q != '0) begin
               lead_d = lead_q - LW'(1);
            end else if (send_cnt_q != '0) begin
               if (!tx_busy) begin
                  tx_load    = 1'b1;
                  rd_ptr_d   = rd_ptr_q + AW'(1);
                  send_cnt_d = send_cnt_q - FW'(1);
               end
            end else if (!tx_busy) begin
               state_d = ST_READY;
               cd_d    = 1'b1;
               trd_d   = 1'b0;
            end
         end
         default: state_d = ST_READY;
      endcase
      if (do_arm) begin
         state_d   = ST_ARMED;
         timer_d   = '0;
         fill_d    = '0;
         trd_d     = 1'b0;
         first_d   = 1'b1;
         adc_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_READY;
         timer_q      <= '0;
         trig_time_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fill_q       <= '0;
         send_cnt_q   <= '0;
         post_cnt_q   <= '0;
         lead_q       <= '0;
         adc_req_q    <= 1'b0;
         trd_q        <= 1'b0;
         cd_q         <= 1'b1;
         first_q      <= 1'b1;
         start_prev_q <= 1'b0;
         sbf_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         trig_time_q  <= trig_time_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fill_q       <= fill_d;
         send_cnt_q   <= send_cnt_d;
         post_cnt_q   <= post_cnt_d;
         lead_q       <= lead_d;
         adc_req_q    <= adc_req_d;
         trd_q        <= trd_d;
         cd_q         <= cd_d;
         first_q      <= first_d;
         start_prev_q <= start;
         sbf_prev_q   <= sbf;
      end
   end

   always_ff @(posedge clk) begin
      prev_q <= prev_d;
      if (wr_en) mem_q[wr_ptr_q] <= adc.adc_data;
   end

   tsc_serial_tx #(.DW(DW), .BIT_CYCLES(BIT_CYCLES)) u_tx (
      .clk   (clk),
      .reset (reset),
      .load  (tx_load),
      .data  (mem_q[rd_ptr_q]),
      .busy  (tx_busy),
      .sd    (sd)
   );

   assign adc.adc_req = adc_req_q;
   assign trd         = trd_q;
   assign cd          = cd_q;
   assign state       = state_q;
   assign trig_time   = trig_time_q;

endmodule

// File: tb/tb_tsc_capture_engine.sv
// Directed bench for tsc_capture_engine: capture, trigger modes, serial readout, reset abort.
module tb_tsc_capture_engine;
   import tsc_pkg::*;

   localparam int DW = 8, DEPTH = 32, POST = 16, BC = 4, TW = 32;

   logic          clk = 1'b0;
   logic          reset, start, sbf;
   logic [DW-1:0] trig_level;
   logic [1:0]    trig_mode;
   logic          trd, sd, cd;
   logic [2:0]    state;
   logic [TW-1:0] trig_time;

   tsc_capture_engine_if #(.DW(DW)) aif ();

   tsc_capture_engine #(.DW(DW), .DEPTH(DEPTH), .POST(POST), .BIT_CYCLES(BC), .TW(TW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .sbf        (sbf),
      .trig_level (trig_level),
      .trig_mode  (trig_mode),
      .adc        (aif),
      .trd        (trd),
      .sd         (sd),
      .cd         (cd),
      .state      (state),
      .trig_time  (trig_time)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ADC model: answers each request with the next table entry, drops ready once req falls.
   logic [DW-1:0] vals [128];
   logic [DW-1:0] exp_bytes [32];
   int n_vals = 0;
   int tbl_id = 0;
   int seen_id = 0;
   int idx = 0;

   always @(negedge clk) begin
      if (tbl_id != seen_id) begin
         seen_id = tbl_id;
         idx = 0;
      end
      if (reset) begin
         aif.adc_rdy = 1'b0;
      end else if (aif.adc_req && !aif.adc_rdy && idx < n_vals) begin
         aif.adc_rdy  = 1'b1;
         aif.adc_data = vals[idx];
         idx++;
      end else if (aif.adc_rdy && !aif.adc_req) begin
         aif.adc_rdy = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_sbf();
      sbf = 1'b1;
      @(negedge clk);
      sbf = 1'b0;
   endtask

   task automatic wait_trd(input string tag);
      int n;
      n = 0;
      while (trd !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_trd"}, trd, 1);
   endtask

   task automatic wait_low(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sd !== 1'b0 && n < 200);
   endtask

   task automatic recv(input string tag, input int count);
      int n;
      logic [DW-1:0] b;
      for (int f = 0; f < count; f++) begin
         wait_low(n);
         chk($sformatf("%s_gap%0d", tag, f), n, (f == 0) ? BC : 1);
         chk($sformatf("%s_cd%0d", tag, f), cd, 0);
         for (int i = 0; i < DW; i++) begin
            repeat (BC) @(negedge clk);
            b[i] = sd;
         end
         repeat (BC) @(negedge clk);
         chk($sformatf("%s_stop%0d", tag, f), sd, 1);
         chk($sformatf("%s_data%0d", tag, f), b, exp_bytes[f]);
         repeat (BC - 1) @(negedge clk);
      end
      @(negedge clk);
      chk({tag, "_cd_done"}, cd, 1);
      chk({tag, "_state_done"}, state, 3'd0);
      chk({tag, "_trd_done"}, trd, 0);
   endtask

   initial begin
      int n;
      logic all_idle;
      reset = 1'b1; start = 1'b0; sbf = 1'b0;
      trig_level = '0; trig_mode = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_state", state, 3'd0);
      chk("rst_req", aif.adc_req, 0);
      chk("rst_trd", trd, 0);
      chk("rst_sd", sd, 1);
      chk("rst_cd", cd, 1);
      chk("rst_trig_time", trig_time, 0);
      reset = 1'b0;
      @(negedge clk);

      // Ramp, mode 0 above 0x40: fires on 0x41 (sample 65, timer 1+2*65)
      for (int i = 0; i < 128; i++) vals[i] = DW'(i);
      n_vals = 128; tbl_id++;
      trig_level = 8'h40; trig_mode = 2'd0;
      pulse_start();
      chk("t1_armed", state, 3'd1);
      wait_trd("t1");
      chk("t1_state", state, 3'd3);
      chk("t1_req", aif.adc_req, 0);
      chk("t1_trig_time", trig_time, 131);

      // Full window: 32 most recent samples 0x32..0x51
      for (int i = 0; i < 32; i++) exp_bytes[i] = DW'(8'h32 + i);
      pulse_sbf();
      chk("t2_cd_low", cd, 0);
      chk("t2_state_send", state, 3'd4);
      recv("t2", 32);

      // Mode 2 rising crossing of 0x80: only 0x85 (sample 3) fires; partial window of 20
      vals[0] = 8'h90; vals[1] = 8'h90; vals[2] = 8'h70; vals[3] = 8'h85;
      for (int i = 4; i < 20; i++) vals[i] = DW'(8'hA0 + i - 4);
      n_vals = 20; tbl_id++;
      trig_level = 8'h80; trig_mode = 2'd2;
      pulse_start();
      wait_trd("t3");
      chk("t3_state", state, 3'd3);
      chk("t3_trig_time", trig_time, 7);
      for (int i = 0; i < 20; i++) exp_bytes[i] = vals[i];
      pulse_sbf();
      recv("t4", 20);

      // start held high: single arm; sbf in ARMED ignored; mode 1 below 0x10 fires on 0x05
      vals[0] = 8'h20; vals[1] = 8'h30; vals[2] = 8'h05;
      for (int i = 3; i < 19; i++) vals[i] = DW'(8'h60 + i);
      n_vals = 19; tbl_id++;
      trig_level = 8'h10; trig_mode = 2'd1;
      start = 1'b1;
      @(negedge clk);
      chk("t6_armed", state, 3'd1);
      pulse_sbf();
      @(negedge clk);
      chk("t6_sbf_ignored", state, 3'd1);
      chk("t6_sbf_cd", cd, 1);
      wait_trd("t6");
      chk("t6_trig_time", trig_time, 5);
      repeat (5) @(negedge clk);
      chk("t6_held_start", state, 3'd3);
      start = 1'b0;
      @(negedge clk);
      vals[0] = 8'h41;
      for (int i = 1; i < 17; i++) vals[i] = DW'(8'h50 + i);
      n_vals = 17; tbl_id++;
      trig_level = 8'h40; trig_mode = 2'd0;
      pulse_start();
      chk("t6_rearm", state, 3'd1);
      chk("t6_rearm_trd", trd, 0);
      wait_trd("t6b");
      chk("t6_timer_cleared", trig_time, 1);

      // Reset in the middle of the first frame (0x41, data bit 2 is 0)
      pulse_sbf();
      wait_low(n);
      chk("t5_gap", n, BC);
      repeat (BC * 3) @(negedge clk);
      chk("t5_mid_frame_sd", sd, 0);
      reset = 1'b1;
      #1;
      chk("t5_sd", sd, 1);
      chk("t5_cd", cd, 1);
      chk("t5_req", aif.adc_req, 0);
      chk("t5_state", state, 3'd0);
      chk("t5_trd", trd, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pulse_sbf();
      all_idle = 1'b1;
      repeat (20) begin
         @(negedge clk);
         all_idle = all_idle & sd & cd;
      end
      chk("t5_sbf_ignored", state, 3'd0);
      chk("t5_line_idle", all_idle, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
